// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single memory-unit bus: captures A/B requests, issues one at a time.
// Define MEMARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (A wins).
module mem_bus_arbiter #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_we,
    input  logic              a_start,
    output logic [DATA_W-1:0] a_q,
    output logic              a_busy,
    output logic              a_err,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_we,
    input  logic              b_start,
    output logic [DATA_W-1:0] b_q,
    output logic              b_busy,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              mem_start,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              mem_busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [ADDR_W-1:0] a_haddr_q, a_haddr_d, b_haddr_q, b_haddr_d;
    logic [DATA_W-1:0] a_hdata_q, a_hdata_d, b_hdata_q, b_hdata_d;
    logic              a_hwe_q, a_hwe_d, b_hwe_q, b_hwe_d;
    logic              grant_q, grant_d, last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              a_err_q, a_err_d, b_err_q, b_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pend_a_q     <= 1'b0;
            pend_b_q     <= 1'b0;
            a_haddr_q    <= '0;
            b_haddr_q    <= '0;
            a_hdata_q    <= '0;
            b_hdata_q    <= '0;
            a_hwe_q      <= 1'b0;
            b_hwe_q      <= 1'b0;
            grant_q      <= PORT_A;
            last_grant_q <= PORT_B;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            a_haddr_q    <= a_haddr_d;
            b_haddr_q    <= b_haddr_d;
            a_hdata_q    <= a_hdata_d;
            b_hdata_q    <= b_hdata_d;
            a_hwe_q      <= a_hwe_d;
            b_hwe_q      <= b_hwe_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            a_err_q      <= a_err_d;
            b_err_q      <= b_err_d;
        end
    end

    always_comb begin
        logic              sel;
        logic              finish;
        logic              timeout;
        logic [DATA_W-1:0] resp;

        state_d      = state_q;
        pend_a_d     = pend_a_q;
        pend_b_d     = pend_b_q;
        a_haddr_d    = a_haddr_q;
        b_haddr_d    = b_haddr_q;
        a_hdata_d    = a_hdata_q;
        b_hdata_d    = b_hdata_q;
        a_hwe_d      = a_hwe_q;
        b_hwe_d      = b_hwe_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = mem_we_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        a_err_d      = 1'b0;
        b_err_d      = 1'b0;
        sel          = PORT_A;
        finish       = 1'b0;
        timeout      = 1'b0;
        resp         = '0;

        // A start while the port is already busy is dropped silently
        if (a_start && !pend_a_q) begin
            pend_a_d  = 1'b1;
            a_haddr_d = a_addr;
            a_hdata_d = a_data;
            a_hwe_d   = a_we;
        end
        if (b_start && !pend_b_q) begin
            pend_b_d  = 1'b1;
            b_haddr_d = b_addr;
            b_hdata_d = b_data;
            b_hwe_d   = b_we;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_a_q || pend_b_q) begin
                    if (pend_a_q && pend_b_q) begin
`ifdef MEMARB_ROUND_ROBIN_EN
                        sel = (last_grant_q == PORT_B) ? PORT_A : PORT_B;
`else
                        sel = PORT_A;
`endif
                    end else begin
                        sel = pend_b_q ? PORT_B : PORT_A;
                    end
                    grant_d      = sel;
                    last_grant_d = sel;
                    mem_addr_d   = (sel == PORT_B) ? b_haddr_q : a_haddr_q;
                    mem_data_d   = (sel == PORT_B) ? b_hdata_q : a_hdata_q;
                    mem_we_d     = (sel == PORT_B) ? b_hwe_q   : a_hwe_q;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // The memory needs one cycle to raise busy, so the first WAIT cycle is blind
                if (cnt_q != '0) begin
                    if (!mem_busy) begin
                        finish = 1'b1;
                        resp   = mem_q;
                    end else if (cnt_q == CNT_LAST) begin
                        finish  = 1'b1;
                        timeout = 1'b1;
                    end
                end
                if (finish) begin
                    state_d = S_IDLE;
                    if (grant_q == PORT_A) begin
                        pend_a_d  = 1'b0;
                        a_rdata_d = resp;
                        a_err_d   = timeout;
                    end else begin
                        pend_b_d  = 1'b0;
                        b_rdata_d = resp;
                        b_err_d   = timeout;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign a_busy    = pend_a_q;
    assign b_busy    = pend_b_q;
    assign a_q       = a_rdata_q;
    assign b_q       = b_rdata_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_we    = mem_we_q;
    assign mem_start = (state_q == S_ISSUE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural memory unit (TIMEOUT_CYC=8).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] a_addr, b_addr, mem_addr;
    logic [31:0] a_data, b_data, mem_data, a_q, b_q, mem_q;
    logic        a_we, b_we, a_start, b_start, a_busy, b_busy, a_err, b_err;
    logic        mem_we, mem_start, mem_busy;

    typedef struct {
        logic [26:0] addr;
        logic [31:0] data;
        logic        we;
        logic [31:0] q;
        logic        err;
    } txn_t;

    txn_t exp_a[$];
    txn_t exp_b[$];
    txn_t exp_issue[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int n_start = 0, last_start_cyc = 0, last_fall_a = 0, last_fall_b = 0;
    bit mon_en = 1'b0, b_seen = 1'b0, hang = 1'b0;
    bit a_busy_prev = 1'b0, b_busy_prev = 1'b0;
    int lat = 0, rem = 0;

    mem_bus_arbiter #(.ADDR_W(27), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .a_addr(a_addr), .a_data(a_data), .a_we(a_we), .a_start(a_start),
        .a_q(a_q), .a_busy(a_busy), .a_err(a_err),
        .b_addr(b_addr), .b_data(b_data), .b_we(b_we), .b_start(b_start),
        .b_q(b_q), .b_busy(b_busy), .b_err(b_err),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_start(mem_start),
        .mem_q(mem_q), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic logic [31:0] rd_val(input logic [26:0] addr);
        if (addr == 27'h100) return 32'hDEADBEEF;
        return 32'h5A00_0000 ^ {5'd0, addr};
    endfunction

    task automatic drive(input bit port, input logic [26:0] addr, input logic [31:0] data,
                         input logic we, input logic err_exp);
        txn_t t;
        t.addr = addr; t.data = data; t.we = we; t.err = err_exp;
        t.q = err_exp ? 32'd0 : (we ? data : rd_val(addr));
        if (!port) begin
            a_addr = addr; a_data = data; a_we = we; a_start = 1'b1;
            exp_a.push_back(t);
        end else begin
            b_addr = addr; b_data = data; b_we = we; b_start = 1'b1;
            exp_b.push_back(t);
        end
        exp_issue.push_back(t);
    endtask

    task automatic end_pulse();
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!a_busy && !b_busy && exp_a.size() == 0 && exp_b.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hang  = 1'b0;
        exp_a.delete(); exp_b.delete(); exp_issue.delete();
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    // Memory unit model: busy for lat negedges after a start, or forever while hang is set
    initial begin
        mem_busy = 1'b0;
        mem_q    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_busy = 1'b0;
                rem = 0;
            end else if (mem_start) begin
                rem      = hang ? 1 : lat;
                mem_q    = mem_we ? mem_data : rd_val(mem_addr);
                mem_busy = hang || (lat > 0);
            end else if (hang) begin
                mem_busy = 1'b1;
            end else begin
                if (rem > 0) rem--;
                mem_busy = (rem > 0);
            end
        end
    end

    // Output monitor: issue order and per-port completions against the scoreboard
    always @(negedge clk) begin
        txn_t e;
        if (mem_start) begin
            n_start++;
            last_start_cyc = cyc;
        end
        if (mon_en) begin
            if (mem_start) begin
                if (exp_issue.size() == 0) chk("issue_extra", 64'(mem_addr), 64'h7FFFFFF);
                else begin
                    e = exp_issue.pop_front();
                    chk("issue_addr", 64'(mem_addr), 64'(e.addr));
                    chk("issue_we",   64'(mem_we),   64'(e.we));
                    chk("issue_data", 64'(mem_data), 64'(e.data));
                end
            end
            if (a_busy_prev && !a_busy) begin
                last_fall_a = cyc;
                if (exp_a.size() == 0) chk("a_done_extra", 64'(a_q), 64'hFFFFFFFF);
                else begin
                    e = exp_a.pop_front();
                    chk("a_q",   64'(a_q),   64'(e.q));
                    chk("a_err", 64'(a_err), 64'(e.err));
                end
            end else if (a_err) chk("a_err_stray", 64'(a_err), 64'd0);
            if (b_busy_prev && !b_busy) begin
                last_fall_b = cyc;
                if (exp_b.size() == 0) chk("b_done_extra", 64'(b_q), 64'hFFFFFFFF);
                else begin
                    e = exp_b.pop_front();
                    chk("b_q",   64'(b_q),   64'(e.q));
                    chk("b_err", 64'(b_err), 64'(e.err));
                end
            end else if (b_err) chk("b_err_stray", 64'(b_err), 64'd0);
        end
        a_busy_prev = a_busy;
        b_busy_prev = b_busy;
        b_seen = b_seen | b_busy;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int n, snap;
        int a_left, b_left, ia, ib;
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; a_we = 1'b0; b_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_busy",    64'(a_busy),    64'd0);
        chk("rst_b_busy",    64'(b_busy),    64'd0);
        chk("rst_mem_start", 64'(mem_start), 64'd0);
        chk("rst_mem_addr",  64'(mem_addr),  64'd0);
        chk("rst_a_q",       64'(a_q),       64'd0);
        chk("rst_b_err",     64'(b_err),     64'd0);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Simultaneous writes after reset: A first, B right after A completes
        lat = 0;
        drive(1'b0, 27'h010, 32'h11, 1'b1, 1'b0);
        drive(1'b1, 27'h020, 32'h22, 1'b1, 1'b0);
        end_pulse();
        wait_drain("t2_drain");
        chk("t2_b_issue_cyc", 64'(last_start_cyc), 64'(last_fall_a + 1));

        // Single read with three busy cycles
        lat = 3; b_seen = 1'b0; n = cyc;
        drive(1'b0, 27'h100, 32'h0, 1'b0, 1'b0);
        end_pulse();
        wait_drain("t1_drain");
        chk("t1_issue_cyc", 64'(last_start_cyc), 64'(n + 2));
        chk("t1_fall_cyc",  64'(last_fall_a),    64'(n + 6));
        chk("t1_b_busy",    64'(b_seen),         64'd0);

        // Re-start while busy is ignored
        lat = 2; snap = n_start;
        drive(1'b0, 27'h180, 32'h0, 1'b0, 1'b0);
        end_pulse();
        a_addr = 27'h280; a_start = 1'b1;
        end_pulse();
        wait_drain("t6_drain");
        chk("t6_one_start", 64'(n_start - snap), 64'd1);

        // Both pending with last grant = A: policy decides the order
        lat = 0;
        drive(1'b0, 27'h1C0, 32'h0, 1'b0, 1'b0);
        end_pulse();
        wait_drain("pol_drain0");
`ifdef MEMARB_ROUND_ROBIN_EN
        drive(1'b1, 27'h1E0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 27'h1D0, 32'h0, 1'b0, 1'b0);
`else
        drive(1'b0, 27'h1D0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 27'h1E0, 32'h0, 1'b0, 1'b0);
`endif
        end_pulse();
        wait_drain("pol_drain1");

        // Continuous re-requests from both ports: grants alternate A,B,A,B,...
        do_reset();
        lat = 1; a_left = 4; b_left = 4; ia = 0; ib = 0;
        for (int c = 0; c < 400; c++) begin
            a_start = 1'b0; b_start = 1'b0;
            if (a_left == 0 && b_left == 0) break;
            if (!a_busy && a_left > 0) begin
                drive(1'b0, 27'(27'h300 + ia), 32'h0, 1'b0, 1'b0);
                ia++; a_left--;
            end
            if (!b_busy && b_left > 0) begin
                drive(1'b1, 27'(27'h400 + ib), 32'h0, 1'b0, 1'b0);
                ib++; b_left--;
            end
            @(negedge clk);
        end
        a_start = 1'b0; b_start = 1'b0;
        wait_drain("t3_drain");
        chk("t3_all_issued", 64'(ia + ib), 64'd8);

        // Memory hangs: B times out after 8 WAIT cycles, then A completes normally
        hang = 1'b1; n = cyc;
        drive(1'b1, 27'h440, 32'h0, 1'b0, 1'b1);
        end_pulse();
        for (int i = 0; i < 50 && b_busy; i++) @(negedge clk);
        @(negedge clk);
        chk("t4_fall_cyc", 64'(last_fall_b), 64'(n + 11));
        hang = 1'b0; lat = 1;
        drive(1'b0, 27'h410, 32'h0, 1'b0, 1'b0);
        end_pulse();
        wait_drain("t4_drain");

        // Reset in the middle of a WAIT
        lat = 20;
        drive(1'b0, 27'h500, 32'h0, 1'b0, 1'b0);
        end_pulse();
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_a_busy",    64'(a_busy),    64'd0);
        chk("t5_a_q",       64'(a_q),       64'd0);
        chk("t5_mem_start", 64'(mem_start), 64'd0);
        chk("t5_mem_addr",  64'(mem_addr),  64'd0);
        chk("t5_mem_we",    64'(mem_we),    64'd0);
        reset = 1'b0;
        exp_a.delete(); exp_b.delete(); exp_issue.delete();
        snap = n_start;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
        chk("t5_no_issue", 64'(n_start - snap), 64'd0);
        lat = 0; n = cyc;
        drive(1'b1, 27'h520, 32'h0, 1'b0, 1'b0);
        end_pulse();
        wait_drain("t5_drain");
        chk("t5_issue_cyc", 64'(last_start_cyc), 64'(n + 2));
        chk("t5_fall_cyc",  64'(last_fall_b),    64'(n + 5));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
